// File: rtl/time_set_controller_pkg.sv
// Shared types and constants for the alarm-clock time-setting front end.
// Holds the edit FSM states, field_sel display codes and the BCD limits of a 24 h clock.
package time_set_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_EDIT_HOUR = 2'd1,
    ST_EDIT_MIN  = 2'd2,
    ST_COMMIT    = 2'd3
  } state_e;

  localparam logic [1:0] FIELD_IDLE   = 2'b00;
  localparam logic [1:0] FIELD_HOUR   = 2'b01;
  localparam logic [1:0] FIELD_MIN    = 2'b10;
  localparam logic [1:0] FIELD_COMMIT = 2'b11;

  localparam int HOUR_MAX = 23;
  localparam int MIN_MAX  = 59;

  localparam logic [1:0] HOUR_MAX_TENS  = 2'(HOUR_MAX / 10);
  localparam logic [3:0] HOUR_MAX_UNITS = 4'(HOUR_MAX % 10);
  localparam logic [3:0] MIN_MAX_TENS   = 4'(MIN_MAX / 10);
  localparam logic [3:0] MIN_MAX_UNITS  = 4'(MIN_MAX % 10);
  localparam logic [3:0] BCD_NINE       = 4'd9;

  typedef struct packed {
    logic [1:0] tens;
    logic [3:0] units;
  } hour_t;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] units;
  } min_t;

  function automatic logic [1:0] field_of(input state_e s);
    logic [1:0] f;
    f = FIELD_IDLE;
    case (s)
      ST_IDLE:      f = FIELD_IDLE;
      ST_EDIT_HOUR: f = FIELD_HOUR;
      ST_EDIT_MIN:  f = FIELD_MIN;
      ST_COMMIT:    f = FIELD_COMMIT;
      default:      f = FIELD_IDLE;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/time_set_controller_button_debouncer.sv
// Pushbutton conditioner: 2-flop synchronizer, stability counter, and a one-cycle
// pulse on the debounced rising edge only (no release pulse, no auto-repeat).
module time_set_controller_button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The counter only runs while the synchronized input disagrees with the
  // accepted level; any bounce back resets it, so the level must hold unbroken.
  always_comb begin
    stable_d = stable_q;
    press_d  = 1'b0;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        press_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= btn_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/time_set_controller.sv
// Pushbutton time/alarm setter: edit hour then minute as BCD digits, then hold the
// selected load strobe long enough for the clock core's 1 s tick to sample it.
module time_set_controller
  import time_set_controller_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES  = 1_000_000,
  parameter int unsigned LOAD_HOLD_CYCLES = 150_000_000,
  parameter int unsigned TIMEOUT_CYCLES   = 1_000_000_000
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       btn_mode_i,
  input  logic       btn_inc_i,
  input  logic       btn_dec_i,
  input  logic       sel_alarm_i,
  output logic [1:0] set_hour1_o,
  output logic [3:0] set_hour0_o,
  output logic [3:0] set_min1_o,
  output logic [3:0] set_min0_o,
  output logic       load_time_o,
  output logic       load_alarm_o,
  output logic [1:0] field_sel_o
);

  localparam int BTN_MODE = 0;
  localparam int BTN_INC  = 1;
  localparam int BTN_DEC  = 2;

  localparam logic [31:0] HOLD_LAST    = 32'(LOAD_HOLD_CYCLES);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  logic [2:0] btn_raw;
  logic [2:0] btn_press;

  assign btn_raw = {btn_dec_i, btn_inc_i, btn_mode_i};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
      time_set_controller_button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debouncer (
        .clock_i(clock_i),
        .reset_i(reset_i),
        .btn_i  (btn_raw[gi]),
        .press_o(btn_press[gi])
      );
    end
  endgenerate

  function automatic hour_t hour_inc(input hour_t h);
    hour_t r;
    if (h.tens == HOUR_MAX_TENS && h.units == HOUR_MAX_UNITS) begin
      r = '0;
    end else if (h.units == BCD_NINE) begin
      r.tens  = h.tens + 2'd1;
      r.units = 4'd0;
    end else begin
      r.tens  = h.tens;
      r.units = h.units + 4'd1;
    end
    return r;
  endfunction

  function automatic hour_t hour_dec(input hour_t h);
    hour_t r;
    if (h.tens == 2'd0 && h.units == 4'd0) begin
      r.tens  = HOUR_MAX_TENS;
      r.units = HOUR_MAX_UNITS;
    end else if (h.units == 4'd0) begin
      r.tens  = h.tens - 2'd1;
      r.units = BCD_NINE;
    end else begin
      r.tens  = h.tens;
      r.units = h.units - 4'd1;
    end
    return r;
  endfunction

  function automatic min_t min_inc(input min_t m);
    min_t r;
    if (m.tens == MIN_MAX_TENS && m.units == MIN_MAX_UNITS) begin
      r = '0;
    end else if (m.units == BCD_NINE) begin
      r.tens  = m.tens + 4'd1;
      r.units = 4'd0;
    end else begin
      r.tens  = m.tens;
      r.units = m.units + 4'd1;
    end
    return r;
  endfunction

  function automatic min_t min_dec(input min_t m);
    min_t r;
    if (m.tens == 4'd0 && m.units == 4'd0) begin
      r.tens  = MIN_MAX_TENS;
      r.units = MIN_MAX_UNITS;
    end else if (m.units == 4'd0) begin
      r.tens  = m.tens - 4'd1;
      r.units = BCD_NINE;
    end else begin
      r.tens  = m.tens;
      r.units = m.units - 4'd1;
    end
    return r;
  endfunction

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  hour_t       hour_q, hour_d;
  min_t        min_q, min_d;
  logic        target_q, target_d;
  logic        sel_sync1_q, sel_sync2_q;
  logic        load_time_q, load_time_d;
  logic        load_alarm_q, load_alarm_d;
  logic [1:0]  field_sel_q, field_sel_d;

  logic mode_p, step_p, up_p;

  // Mode beats inc/dec; simultaneous inc and dec cancel out.
  assign mode_p = btn_press[BTN_MODE];
  assign step_p = btn_press[BTN_INC] ^ btn_press[BTN_DEC];
  assign up_p   = btn_press[BTN_INC];

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      hour_q       <= '0;
      min_q        <= '0;
      target_q     <= 1'b0;
      sel_sync1_q  <= 1'b0;
      sel_sync2_q  <= 1'b0;
      load_time_q  <= 1'b0;
      load_alarm_q <= 1'b0;
      field_sel_q  <= FIELD_IDLE;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hour_q       <= hour_d;
      min_q        <= min_d;
      target_q     <= target_d;
      sel_sync1_q  <= sel_alarm_i;
      sel_sync2_q  <= sel_sync1_q;
      load_time_q  <= load_time_d;
      load_alarm_q <= load_alarm_d;
      field_sel_q  <= field_sel_d;
    end
  end

  // cnt_q is the idle timer in the edit states and the hold timer in COMMIT.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 32'd1;
    hour_d   = hour_q;
    min_d    = min_q;
    target_d = target_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (mode_p) begin
          state_d  = ST_EDIT_HOUR;
          target_d = sel_sync2_q;
        end
      end
      ST_EDIT_HOUR: begin
        if (mode_p) begin
          state_d = ST_EDIT_MIN;
          cnt_d   = '0;
        end else if (step_p) begin
          hour_d = up_p ? hour_inc(hour_q) : hour_dec(hour_q);
          cnt_d  = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = ST_IDLE;
        end
      end
      ST_EDIT_MIN: begin
        if (mode_p) begin
          state_d = ST_COMMIT;
          cnt_d   = '0;
        end else if (step_p) begin
          min_d = up_p ? min_inc(min_q) : min_dec(min_q);
          cnt_d = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = ST_IDLE;
        end
      end
      ST_COMMIT: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Loads start the cycle after COMMIT is entered and stop as it is left,
  // giving exactly LOAD_HOLD_CYCLES high cycles.
  always_comb begin
    field_sel_d  = field_of(state_d);
    load_time_d  = 1'b0;
    load_alarm_d = 1'b0;
    if (state_q == ST_COMMIT && state_d == ST_COMMIT) begin
      load_time_d  = ~target_q;
      load_alarm_d = target_q;
    end
  end

  assign set_hour1_o  = hour_q.tens;
  assign set_hour0_o  = hour_q.units;
  assign set_min1_o   = min_q.tens;
  assign set_min0_o   = min_q.units;
  assign load_time_o  = load_time_q;
  assign load_alarm_o = load_alarm_q;
  assign field_sel_o  = field_sel_q;

endmodule

// File: tb/tb_time_set_controller.sv
// Self-checking bench for time_set_controller using small timing parameters and a
// reference model that keeps the staged time as plain hour/minute integers.
module tb_time_set_controller;

  localparam int DEB  = 4;
  localparam int HOLD = 8;
  localparam int TOUT = 64;

  localparam logic [2:0] OP_MODE = 3'b001;
  localparam logic [2:0] OP_INC  = 3'b010;
  localparam logic [2:0] OP_DEC  = 3'b100;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_mode = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0, sel_alarm = 1'b0;
  logic [1:0] set_hour1;
  logic [3:0] set_hour0, set_min1, set_min0;
  logic       load_time, load_alarm;
  logic [1:0] field_sel;

  time_set_controller #(
    .DEBOUNCE_CYCLES (DEB),
    .LOAD_HOLD_CYCLES(HOLD),
    .TIMEOUT_CYCLES  (TOUT)
  ) dut (
    .clock_i     (clk),
    .reset_i     (reset),
    .btn_mode_i  (btn_mode),
    .btn_inc_i   (btn_inc),
    .btn_dec_i   (btn_dec),
    .sel_alarm_i (sel_alarm),
    .set_hour1_o (set_hour1),
    .set_hour0_o (set_hour0),
    .set_min1_o  (set_min1),
    .set_min0_o  (set_min0),
    .load_time_o (load_time),
    .load_alarm_o(load_alarm),
    .field_sel_o (field_sel)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: staged time as integers, field 0 idle / 1 hour / 2 minute.
  int m_h = 0, m_m = 0, m_field = 0;
  bit m_target = 1'b0;
  bit m_load_t = 1'b0, m_load_a = 1'b0;

  // Load monitor, sampled on the falling edge.
  int lt_total = 0, la_total = 0, both_total = 0, outside_total = 0;
  always @(negedge clk) begin
    if (load_time) lt_total++;
    if (load_alarm) la_total++;
    if (load_time && load_alarm) both_total++;
    if ((load_time || load_alarm) && field_sel != 2'b11) outside_total++;
  end

  function automatic logic [15:0] dut_vec();
    return {set_hour1, set_hour0, set_min1, set_min0, field_sel};
  endfunction

  function automatic logic [15:0] exp_vec();
    return {2'(m_h / 10), 4'(m_h % 10), 4'(m_m / 10), 4'(m_m % 10), 2'(m_field)};
  endfunction

  function automatic void model_press(input bit m, input bit i, input bit d);
    m_load_t = 1'b0;
    m_load_a = 1'b0;
    if (m) begin
      case (m_field)
        0: begin m_field = 1; m_target = sel_alarm; end
        1: m_field = 2;
        default: begin
          m_field = 0;
          if (m_target) m_load_a = 1'b1; else m_load_t = 1'b1;
        end
      endcase
    end else if (i != d) begin
      if (m_field == 1) m_h = i ? (m_h + 1) % 24 : (m_h + 23) % 24;
      else if (m_field == 2) m_m = i ? (m_m + 1) % 60 : (m_m + 59) % 60;
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    m_h = 0; m_m = 0; m_field = 0; m_target = 1'b0; m_load_t = 1'b0; m_load_a = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Press the given buttons together for `hold` cycles, then release and let things settle.
  task automatic step(input logic [2:0] op, input int hold);
    @(negedge clk);
    btn_mode = op[0]; btn_inc = op[1]; btn_dec = op[2];
    model_press(op[0], op[1], op[2]);
    repeat (hold) @(negedge clk);
    btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
    repeat (16) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({load_time, load_alarm, dut_vec()} !== 18'd0)
      $display("FAIL reset_state got=%h exp=0", {load_time, load_alarm, dut_vec()});
    else n_pass++;
    reset = 1'b0;
    m_h = 0; m_m = 0; m_field = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic_commit();
    logic [2:0] ops[$];
    int lt0, la0;
    do_reset();
    ops = '{OP_MODE, OP_DEC, OP_MODE, OP_DEC, OP_MODE};
    foreach (ops[k]) begin
      lt0 = lt_total; la0 = la_total;
      step(ops[k], 8);
      n_checks++;
      if (dut_vec() !== exp_vec())
        $display("FAIL basic_vec step=%0d got=%h exp=%h", k, dut_vec(), exp_vec());
      else n_pass++;
      n_checks++;
      if (lt_total - lt0 != (m_load_t ? HOLD : 0) || la_total - la0 != 0 ||
          both_total != 0 || outside_total != 0)
        $display("FAIL basic_load step=%0d lt=%0d la=%0d both=%0d outside=%0d exp_lt=%0d",
                 k, lt_total - lt0, la_total - la0, both_total, outside_total, m_load_t ? HOLD : 0);
      else n_pass++;
    end
    n_checks++;
    if ({load_time, dut_vec()} !== {1'b0, 2'd2, 4'd3, 4'd5, 4'd9, 2'd0})
      $display("FAIL basic_final got=%h exp=%h", {load_time, dut_vec()},
               {1'b0, 2'd2, 4'd3, 4'd5, 4'd9, 2'd0});
    else n_pass++;
  endtask

  task automatic test_alarm_target();
    logic [2:0] ops[$];
    int lt0, la0;
    do_reset();
    sel_alarm = 1'b1;
    repeat (4) @(negedge clk);
    ops = '{OP_MODE};
    repeat (3) ops.push_back(OP_INC);
    ops.push_back(OP_MODE);
    repeat (10) ops.push_back(OP_INC);
    ops.push_back(OP_MODE);
    foreach (ops[k]) begin
      lt0 = lt_total; la0 = la_total;
      step(ops[k], 7);
      if (k == 0) sel_alarm = 1'b0;
      n_checks++;
      if (dut_vec() !== exp_vec() || lt_total - lt0 != (m_load_t ? HOLD : 0) ||
          la_total - la0 != (m_load_a ? HOLD : 0))
        $display("FAIL alarm_step step=%0d got=%h exp=%h lt=%0d la=%0d",
                 k, dut_vec(), exp_vec(), lt_total - lt0, la_total - la0);
      else n_pass++;
    end
    n_checks++;
    if (dut_vec() !== {2'd0, 4'd3, 4'd1, 4'd0, 2'd0} || la_total - la0 != HOLD || lt_total - lt0 != 0)
      $display("FAIL alarm_final got=%h la=%0d lt=%0d exp=%h la=%0d lt=0",
               dut_vec(), la_total - la0, lt_total - lt0, {2'd0, 4'd3, 4'd1, 4'd0, 2'd0}, HOLD);
    else n_pass++;
  endtask

  task automatic test_glitch();
    do_reset();
    step(OP_MODE, 8);
    @(negedge clk); btn_inc = 1'b1;
    repeat (2) @(negedge clk); btn_inc = 1'b0;
    repeat (6) @(negedge clk); btn_inc = 1'b1;
    repeat (3) @(negedge clk); btn_inc = 1'b0;
    repeat (12) @(negedge clk);
    n_checks++;
    if (dut_vec() !== exp_vec()) $display("FAIL glitch_ignored got=%h exp=%h", dut_vec(), exp_vec());
    else n_pass++;
    step(OP_INC, 6);
    n_checks++;
    if (dut_vec() !== exp_vec()) $display("FAIL glitch_single got=%h exp=%h", dut_vec(), exp_vec());
    else n_pass++;
    // A 100-cycle hold yields one increment; the idle timer then expires during the hold.
    step(OP_INC, 100);
    m_field = 0;
    n_checks++;
    if (dut_vec() !== exp_vec() || dut_vec() !== {2'd0, 4'd2, 4'd0, 4'd0, 2'd0})
      $display("FAIL glitch_long_hold got=%h exp=%h", dut_vec(), exp_vec());
    else n_pass++;
  endtask

  task automatic test_boundaries();
    logic [2:0] ops[$];
    do_reset();
    ops = '{OP_MODE};
    repeat (10) ops.push_back(OP_INC);
    foreach (ops[k]) begin
      step(ops[k], 6);
      n_checks++;
      if (dut_vec() !== exp_vec()) $display("FAIL bound_hour step=%0d got=%h exp=%h", k, dut_vec(), exp_vec());
      else n_pass++;
    end
    do_reset();
    ops = '{OP_MODE, OP_DEC, OP_INC, OP_INC, OP_MODE, OP_DEC, OP_INC};
    foreach (ops[k]) begin
      step(ops[k], 6);
      n_checks++;
      if (dut_vec() !== exp_vec()) $display("FAIL bound_wrap step=%0d got=%h exp=%h", k, dut_vec(), exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (dut_vec() !== {2'd0, 4'd1, 4'd0, 4'd0, 2'd2})
      $display("FAIL bound_final got=%h exp=%h", dut_vec(), {2'd0, 4'd1, 4'd0, 4'd0, 2'd2});
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    logic [2:0] ops[$];
    do_reset();
    ops = '{OP_MODE, OP_INC, OP_INC | OP_DEC, OP_MODE | OP_INC, OP_DEC | OP_INC};
    foreach (ops[k]) begin
      step(ops[k], 7);
      n_checks++;
      if (dut_vec() !== exp_vec()) $display("FAIL simul step=%0d got=%h exp=%h", k, dut_vec(), exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_timeout();
    int lt0, la0;
    do_reset();
    step(OP_MODE, 8);
    step(OP_MODE, 8);
    lt0 = lt_total; la0 = la_total;
    repeat (30) @(negedge clk);
    n_checks++;
    if (dut_vec() !== exp_vec()) $display("FAIL timeout_early got=%h exp=%h", dut_vec(), exp_vec());
    else n_pass++;
    repeat (40) @(negedge clk);
    m_field = 0;
    n_checks++;
    if (dut_vec() !== exp_vec() || lt_total != lt0 || la_total != la0)
      $display("FAIL timeout_idle got=%h exp=%h loads=%0d", dut_vec(), exp_vec(),
               (lt_total - lt0) + (la_total - la0));
    else n_pass++;
  endtask

  task automatic test_reset_in_commit();
    int waited;
    do_reset();
    step(OP_MODE, 8);
    step(OP_INC, 8);
    step(OP_MODE, 8);
    @(negedge clk);
    btn_mode = 1'b1;
    waited = 0;
    while (!load_time && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (!load_time) $display("FAIL commit_wait got=load_time low after %0d cycles exp=high", waited);
    else n_pass++;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    btn_mode = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({load_time, load_alarm, dut_vec()} !== 18'd0)
      $display("FAIL commit_reset got=%h exp=0", {load_time, load_alarm, dut_vec()});
    else n_pass++;
    reset = 1'b0;
    m_h = 0; m_m = 0; m_field = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    logic [2:0] op;
    int r, lt0, la0;
    do_reset();
    for (int k = 0; k < 40; k++) begin
      r = int'($urandom_range(0, 9));
      op = (r < 2) ? OP_MODE : (r < 6) ? OP_INC : (r < 9) ? OP_DEC : (OP_INC | OP_DEC);
      sel_alarm = 1'($urandom_range(0, 1));
      repeat (3) @(negedge clk);
      lt0 = lt_total; la0 = la_total;
      step(op, int'($urandom_range(5, 10)));
      n_checks++;
      if (dut_vec() !== exp_vec() || lt_total - lt0 != (m_load_t ? HOLD : 0) ||
          la_total - la0 != (m_load_a ? HOLD : 0) || both_total != 0 || outside_total != 0)
        $display("FAIL random op=%b k=%0d got=%h exp=%h lt=%0d la=%0d both=%0d outside=%0d",
                 op, k, dut_vec(), exp_vec(), lt_total - lt0, la_total - la0, both_total, outside_total);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic_commit();
    test_alarm_target();
    test_glitch();
    test_boundaries();
    test_simultaneous();
    test_timeout();
    test_reset_in_commit();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
